// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES datapath: steps one 128-bit block through
// the initial AddRoundKey, NUM_ROUNDS-1 full rounds and the final round, then holds done.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             opt_mode,
    input  logic             key_ready,
    input  logic             abort,
    input  logic             out_ready,
    output logic             busy,
    output logic             load_state,
    output logic             addkey_en,
    output logic             round_en,
    output logic             mix_en,
    output logic             inv,
    output logic [IDX_W-1:0] round_idx,
    output logic             done,
    output logic [2:0]       dbg_state
);

    // Handshake: start is accepted only while busy=0; done stays high until out_ready=1
    // is seen in the same cycle, and the block leaves DONE on that edge.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_KEY = 3'd1,
        S_LOAD     = 3'd2,
        S_ROUND    = 3'd3,
        S_FINAL    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cnt_next;
    logic             r_inv;
    logic             w_accept;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_inv <= opt_mode;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        busy       = 1'b1;
        load_state = 1'b0;
        addkey_en  = 1'b0;
        round_en   = 1'b0;
        mix_en     = 1'b0;
        round_idx  = '0;
        done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = key_ready ? S_LOAD : S_WAIT_KEY;
                end
            end
            S_WAIT_KEY: begin
                if (key_ready) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                load_state = 1'b1;
                addkey_en  = 1'b1;
                round_idx  = r_inv ? LAST_IDX : '0;
                w_cnt_next = IDX_W'(1);
                w_next     = S_ROUND;
            end
            S_ROUND: begin
                round_en   = 1'b1;
                mix_en     = 1'b1;
                addkey_en  = 1'b1;
                round_idx  = r_inv ? (LAST_IDX - r_cnt) : r_cnt;
                w_cnt_next = r_cnt + IDX_W'(1);
                if (r_cnt == LAST_IDX - IDX_W'(1)) begin
                    w_next = S_FINAL;
                end
            end
            S_FINAL: begin
                round_en  = 1'b1;
                addkey_en = 1'b1;
                round_idx = r_inv ? '0 : LAST_IDX;
                w_next    = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Abort cancels any in-flight block; it never blocks a start seen in IDLE.
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
        if (w_next == S_IDLE) begin
            w_cnt_next = '0;
        end
    end

    assign inv       = r_inv;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a step-count reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized stretch.
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          opt_mode = 1'b0;
  logic          key_ready = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, load_state, addkey_en, round_en, mix_en, inv, done;
  logic [IW-1:0] round_idx;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: a block is a single step counter t (0 = key load, 1..NR = rounds,
  // NR+1 = result held), the encryption key index equals t, decryption uses NR-t.
  bit m_busy = 1'b0;
  bit m_wait = 1'b0;
  bit m_inv = 1'b0;
  int m_t = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  aes_round_sequencer #(.NUM_ROUNDS(NR), .IDX_W(IW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .opt_mode  (opt_mode),
    .key_ready (key_ready),
    .abort     (abort),
    .out_ready (out_ready),
    .busy      (busy),
    .load_state(load_state),
    .addkey_en (addkey_en),
    .round_en  (round_en),
    .mix_en    (mix_en),
    .inv       (inv),
    .round_idx (round_idx),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy <= 1'b0;
      m_wait <= 1'b0;
      m_inv  <= 1'b0;
      m_t    <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_inv  <= opt_mode;
        m_wait <= !key_ready;
        m_t    <= 0;
      end
    end else if (abort) begin
      m_busy <= 1'b0;
    end else if (m_wait) begin
      if (key_ready) m_wait <= 1'b0;
    end else if (m_t == NR + 1) begin
      if (out_ready) m_busy <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic logic [IW+6:0] model_out();
    bit act;
    logic [IW-1:0] idx;
    act = m_busy && !m_wait;
    idx = '0;
    if (act && m_t <= NR) idx = IW'(m_inv ? NR - m_t : m_t);
    return {m_busy, act && m_t == 0, act && m_t <= NR, act && m_t >= 1 && m_t <= NR,
            act && m_t >= 1 && m_t < NR, m_inv, idx, act && m_t == NR + 1};
  endfunction

  function automatic logic [IW+6:0] dut_out();
    return {busy, load_state, addkey_en, round_en, mix_en, inv, round_idx, done};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) check("outputs_vs_model", 32'(dut_out()), 32'(model_out()));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Called in the LOAD cycle (cycle 1); returns the cycle number on which done is seen.
  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic run_block(input bit mode);
    int c;
    int n_round;
    logic [IW-1:0] first_idx;
    logic [IW-1:0] final_idx;
    start = 1'b1; opt_mode = mode; key_ready = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("load_state", load_state, 1);
    check("load_idx", round_idx, mode ? NR : 0);
    c = 1; n_round = 0; first_idx = '1; final_idx = '1;
    while (!done && c < 40) begin
      opt_mode = 1'($urandom);
      key_ready = 1'($urandom);
      tick();
      c++;
      if (round_en && mix_en) begin
        if (n_round == 0) first_idx = round_idx;
        n_round++;
      end
      if (round_en && !mix_en) final_idx = round_idx;
    end
    check("done_cycle", c, 12);
    check("round_count", n_round, NR - 1);
    check("first_round_idx", first_idx, mode ? 9 : 1);
    check("final_idx", final_idx, mode ? 0 : 10);
    check("inv_held", inv, mode);
    key_ready = 1'b1;
    tick();
    check("busy_after_done", busy, 0);
  endtask

  task automatic run_wait_key();
    int c;
    start = 1'b1; key_ready = 1'b0; opt_mode = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("wait_busy", busy, 1);
      check("wait_no_enables", {load_state, addkey_en, round_en, mix_en, done}, 0);
      if (i < 4) tick();
    end
    key_ready = 1'b1;
    tick();
    check("wait_then_load", load_state, 1);
    wait_done(c);
    check("wait_latency", c, 12);
    tick();
  endtask

  task automatic run_hold();
    int c;
    int n;
    out_ready = 1'b0; start = 1'b1; key_ready = 1'b1; opt_mode = 1'($urandom);
    tick();
    start = 1'b0;
    wait_done(c);
    check("hold_latency", c, 12);
    n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done && !addkey_en && !round_en && !load_state && !mix_en && round_idx == 0) n++;
    end
    check("done_held_cycles", n, 5);
    out_ready = 1'b1; start = 1'b1;
    tick();
    check("start_ignored_in_done", busy, 0);
    tick();
    start = 1'b0;
    check("accept_after_done", load_state, 1);
    wait_done(c);
    check("back_to_back_latency", c, 12);
    tick();
  endtask

  task automatic run_abort();
    int c;
    bit found;
    start = 1'b1; opt_mode = 1'b0; key_ready = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (round_en && mix_en && round_idx == 5) found = 1'b1;
    end
    check("reach_round5", found, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_no_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_load", load_state, 1);
    check("restart_idx", round_idx, 0);
    wait_done(c);
    check("restart_latency", c, 12);
    tick();
  endtask

  task automatic run_reset();
    start = 1'b1; opt_mode = 1'b1; key_ready = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("in_round_before_reset", round_en && mix_en, 1);
    #2 n_rst = 1'b0;
    #1 check("async_reset_outputs", 32'(dut_out()), 0);
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("post_reset_idle", {busy, done}, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 chk_en = 1'b1;
    tick();
    check("reset_outputs", 32'(dut_out()), 0);
    tick();
    n_rst = 1'b1;
    run_block(1'b0);
    run_block(1'b1);
    run_wait_key();
    run_hold();
    run_abort();
    run_reset();
    repeat (3000) begin
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      key_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      opt_mode  = 1'($urandom);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
